int_operand_stage: RTL and testbench

- Operand-fetch/bypass stage directly upstream of the integer ALU.
- Accepts an issued integer op with register-file read data, resolves each source operand (zero register, immediate, forwarding network, register file), and registers the result into a 2-entry skid buffer.
- Drives the ALU's code and operand A/B inputs under a valid/ready handshake, with a flush for branch mispredict recovery.

---
 rtl/int_operand_stage.sv | 151 +++++++++++++++
 tb/tb_int_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_operand_stage.sv
// int_operand_stage: operand resolution and 2-entry skid buffer feeding the integer ALU.
// Each source operand resolves to one of: zero register (tag 0), immediate (B only),
// forwarding network, or register-file read data. Values are frozen once captured.
// Optional feature: define RSD_OPERAND_BYPASS_EN to enable forwarding-network resolution.
// Without it, bypValid/bypTag/bypData are ignored and no tag comparators are built.
`timescale 1ns/1ps
module int_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int BYP_NUM    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [CODE_WIDTH-1:0]         inCode,
  input  logic [TAG_WIDTH-1:0]          inTagA,
  input  logic [TAG_WIDTH-1:0]          inTagB,
  input  logic [DATA_WIDTH-1:0]         inRegA,
  input  logic [DATA_WIDTH-1:0]         inRegB,
  input  logic                          inUseImm,
  input  logic [DATA_WIDTH-1:0]         inImm,
  input  logic [TAG_WIDTH-1:0]          inDstTag,
  input  logic [BYP_NUM-1:0]            bypValid,
  input  logic [BYP_NUM*TAG_WIDTH-1:0]  bypTag,
  input  logic [BYP_NUM*DATA_WIDTH-1:0] bypData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [CODE_WIDTH-1:0]         outCode,
  output logic [DATA_WIDTH-1:0]         outOpA,
  output logic [DATA_WIDTH-1:0]         outOpB,
  output logic [TAG_WIDTH-1:0]          outDstTag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [CODE_WIDTH-1:0] code;
    logic [DATA_WIDTH-1:0] opA;
    logic [DATA_WIDTH-1:0] opB;
    logic [TAG_WIDTH-1:0]  dst;
  } entry_t;

  occ_t   state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   consume;

`ifdef RSD_OPERAND_BYPASS_EN
  // Zero register wins, then the lowest-index matching forwarding source, then the register file.
  function automatic logic [DATA_WIDTH-1:0] resolve(input logic [TAG_WIDTH-1:0]  tag,
                                                    input logic [DATA_WIDTH-1:0] rf);
    logic [DATA_WIDTH-1:0] val;
    logic                  hit;
    val = rf;
    hit = 1'b0;
    for (int unsigned i = 0; i < BYP_NUM; i++) begin
      if (!hit && bypValid[i] && (bypTag[i*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        val = bypData[i*DATA_WIDTH +: DATA_WIDTH];
        hit = 1'b1;
      end
    end
    if (tag == '0) val = '0;
    return val;
  endfunction
`else
  // Forwarding inputs stay on the port list but are deliberately unconsumed.
  logic unused_byp;
  assign unused_byp = ^{bypValid, bypTag, bypData};

  function automatic logic [DATA_WIDTH-1:0] resolve(input logic [TAG_WIDTH-1:0]  tag,
                                                    input logic [DATA_WIDTH-1:0] rf);
    return (tag == '0) ? '0 : rf;
  endfunction
`endif

  assign accept  = inValid && inReady;
  assign consume = outValid && outReady;

  // Build the resolved entry for the op presented this cycle.
  always_comb begin
    in_entry      = '0;
    in_entry.code = inCode;
    in_entry.opA  = resolve(inTagA, inRegA);
    in_entry.opB  = inUseImm ? inImm : resolve(inTagB, inRegB);
    in_entry.dst  = inDstTag;
  end

  // Occupancy transitions and entry movement; flush only clears occupancy, data is left as-is.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake flags decode straight from the state register, so inReady never depends on outReady.
  assign outValid  = (state_q != EMPTY);
  assign inReady   = (state_q != TWO);
  assign outCode   = main_q.code;
  assign outOpA    = main_q.opA;
  assign outOpB    = main_q.opB;
  assign outDstTag = main_q.dst;

endmodule

// File: tb/tb_int_operand_stage.sv
// Testbench for int_operand_stage: a queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_int_operand_stage;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TW = 6;
  localparam int BN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          inValid;
  logic          inReady;
  logic [CW-1:0] inCode;
  logic [TW-1:0] inTagA, inTagB, inDstTag;
  logic [DW-1:0] inRegA, inRegB, inImm;
  logic          inUseImm;
  logic [BN-1:0]    bypValid;
  logic [BN*TW-1:0] bypTag;
  logic [BN*DW-1:0] bypData;
  logic          outValid;
  logic          outReady;
  logic [CW-1:0] outCode;
  logic [DW-1:0] outOpA, outOpB;
  logic [TW-1:0] outDstTag;

  int checks = 0;
  int errors = 0;

  int_operand_stage #(
    .DATA_WIDTH(DW),
    .CODE_WIDTH(CW),
    .TAG_WIDTH (TW),
    .BYP_NUM   (BN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .inValid  (inValid),
    .inReady  (inReady),
    .inCode   (inCode),
    .inTagA   (inTagA),
    .inTagB   (inTagB),
    .inRegA   (inRegA),
    .inRegB   (inRegB),
    .inUseImm (inUseImm),
    .inImm    (inImm),
    .inDstTag (inDstTag),
    .bypValid (bypValid),
    .bypTag   (bypTag),
    .bypData  (bypData),
    .outValid (outValid),
    .outReady (outReady),
    .outCode  (outCode),
    .outOpA   (outOpA),
    .outOpB   (outOpB),
    .outDstTag(outDstTag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] code;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] dst;
  } op_t;

  op_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_operand(input logic [TW-1:0] tag, input logic [DW-1:0] rf);
    if (tag == 0) return '0;
`ifdef RSD_OPERAND_BYPASS_EN
    for (int i = 0; i < BN; i++)
      if (bypValid[i] && bypTag[i*TW +: TW] == tag) return bypData[i*DW +: DW];
`endif
    return rf;
  endfunction

  // Reference model: a FIFO of at most two ops, updated at each edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      bit acc, con;
      op_t n;
      acc = inValid && (mq.size() < 2);
      con = (mq.size() > 0) && outReady;
      n.code = inCode;
      n.a    = ref_operand(inTagA, inRegA);
      n.b    = inUseImm ? inImm : ref_operand(inTagB, inRegB);
      n.dst  = inDstTag;
      if (flush) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(n);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_outValid", outValid, mq.size() > 0);
      chk("m_inReady", inReady, mq.size() < 2);
      if (mq.size() > 0) begin
        chk("m_outCode", outCode, mq[0].code);
        chk("m_outOpA", outOpA, mq[0].a);
        chk("m_outOpB", outOpB, mq[0].b);
        chk("m_outDstTag", outDstTag, mq[0].dst);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CW-1:0] code, input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                       input logic [DW-1:0] ra, input logic [DW-1:0] rb, input logic ui,
                       input logic [DW-1:0] imm, input logic [TW-1:0] dst);
    inValid = 1'b1; inCode = code; inTagA = ta; inTagB = tb;
    inRegA = ra; inRegB = rb; inUseImm = ui; inImm = imm; inDstTag = dst;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    inCode = '0; inTagA = '0; inTagB = '0; inRegA = '0; inRegB = '0;
    inUseImm = 1'b0; inImm = '0; inDstTag = '0;
    bypValid = '0; bypTag = '0; bypData = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 1);
    chk("rst_outCode", outCode, 0);
    chk("rst_outOpA", outOpA, 0);
    chk("rst_outOpB", outOpB, 0);
    chk("rst_outDstTag", outDstTag, 0);

    // Basic ADD: outputs appear one cycle after acceptance
    drive(4'd1, 6'd3, 6'd4, 32'd5, 32'd7, 1'b0, 32'd0, 6'd10);
    #2;
    chk("pre_outOpA", outOpA, 0);
    step();
    chk("add_outValid", outValid, 1);
    chk("add_outOpA", outOpA, 32'd5);
    chk("add_outOpB", outOpB, 32'd7);
    chk("add_outCode", outCode, 4'd1);

    // Zero register on A, immediate on B
    drive(4'd2, 6'd0, 6'd4, 32'hDEAD, 32'd123, 1'b1, 32'hFFFF_FFF0, 6'd11);
    step();
    chk("zero_outOpA", outOpA, 32'd0);
    chk("imm_outOpB", outOpB, 32'hFFFF_FFF0);

    // Both forwarding sources hit: index 0 wins
    bypValid = 2'b11; bypTag = {6'd9, 6'd9}; bypData = {32'h22, 32'h11};
    drive(4'd3, 6'd9, 6'd5, 32'h33, 32'h44, 1'b0, 32'd0, 6'd12);
    step();
`ifdef RSD_OPERAND_BYPASS_EN
    chk("byp_prio_outOpA", outOpA, 32'h11);
`else
    chk("byp_off_outOpA", outOpA, 32'h33);
`endif
    chk("byp_miss_outOpB", outOpB, 32'h44);

    // Only source 1 hits
    bypValid = 2'b10;
    drive(4'd3, 6'd9, 6'd0, 32'h55, 32'h66, 1'b0, 32'd0, 6'd13);
    step();
`ifdef RSD_OPERAND_BYPASS_EN
    chk("byp1_outOpA", outOpA, 32'h22);
`else
    chk("byp1_off_outOpA", outOpA, 32'h55);
`endif
    chk("byp1_zero_outOpB", outOpB, 32'h0);
    bypValid = '0;
    inValid = 1'b0;
    step();
    chk("drain_outValid", outValid, 0);

    // Stall with three back-to-back ops A, B, C
    outReady = 1'b0;
    drive(4'd4, 6'd1, 6'd2, 32'hA, 32'hA1, 1'b0, 32'd0, 6'd20);
    step();
    chk("stall1_inReady", inReady, 1);
    chk("stall1_outOpA", outOpA, 32'hA);
    drive(4'd5, 6'd1, 6'd2, 32'hB, 32'hB1, 1'b0, 32'd0, 6'd21);
    step();
    chk("stall2_inReady", inReady, 0);
    chk("stall2_outOpA", outOpA, 32'hA);
    drive(4'd6, 6'd1, 6'd2, 32'hC, 32'hC1, 1'b0, 32'd0, 6'd22);
    // Forwarding appearing now must not alter the frozen entries
    bypValid = 2'b01; bypTag = {6'd0, 6'd1}; bypData = {32'h0, 32'hBAD};
    step();
    chk("stall3_inReady", inReady, 0);
    chk("stall3_outOpA", outOpA, 32'hA);
    chk("stall3_outOpB", outOpB, 32'hA1);
    bypValid = '0;
    outReady = 1'b1;
    step();
    chk("order_B_outOpA", outOpA, 32'hB);
    chk("order_B_inReady", inReady, 1);
    step();
    chk("order_C_outOpA", outOpA, 32'hC);
    inValid = 1'b0;
    step();
    chk("order_end_outValid", outValid, 0);

    // Flush in TWO with a concurrent incoming op
    outReady = 1'b0;
    drive(4'd7, 6'd1, 6'd2, 32'h101, 32'd0, 1'b0, 32'd0, 6'd30);
    step();
    drive(4'd7, 6'd1, 6'd2, 32'h102, 32'd0, 1'b0, 32'd0, 6'd31);
    step();
    chk("pre_flush_inReady", inReady, 0);
    drive(4'd7, 6'd1, 6'd2, 32'h103, 32'd0, 1'b0, 32'd0, 6'd32);
    flush = 1'b1;
    step();
    flush = 1'b0;
    inValid = 1'b0;
    chk("flush_outValid", outValid, 0);
    chk("flush_inReady", inReady, 1);
    outReady = 1'b1;
    step(); step(); step();
    chk("post_flush_outValid", outValid, 0);

    // Asynchronous reset mid-cycle while in TWO
    outReady = 1'b0;
    drive(4'd8, 6'd1, 6'd2, 32'h201, 32'd0, 1'b0, 32'd0, 6'd40);
    step();
    drive(4'd8, 6'd1, 6'd2, 32'h202, 32'd0, 1'b0, 32'd0, 6'd41);
    step();
    inValid = 1'b0;
    chk("pre_arst_outValid", outValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outValid", outValid, 0);
    chk("arst_inReady", inReady, 1);
    step();
    rst_n = 1'b1;
    outReady = 1'b1;
    step();

    // Mixed traffic with stalls, forwarding and occasional flush; the model checks every cycle
    for (int k = 0; k < 80; k++) begin
      inValid  = 1'($urandom_range(0, 1));
      outReady = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      inCode   = 4'($urandom);
      inTagA   = 6'($urandom_range(0, 7));
      inTagB   = 6'($urandom_range(0, 7));
      inRegA   = $urandom;
      inRegB   = $urandom;
      inUseImm = ($urandom_range(0, 3) == 0);
      inImm    = $urandom;
      inDstTag = 6'($urandom);
      bypValid = 2'($urandom);
      bypTag   = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      bypData  = {32'($urandom), 32'($urandom)};
      step();
    end
    inValid = 1'b0; flush = 1'b0; outReady = 1'b1; bypValid = '0;
    step(); step(); step();
    chk("final_outValid", outValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
